// File: rtl/muldiv_seq_pkg.sv
// Shared constants, funct decode helpers and state encoding for the HI/LO multiply/divide sequencer.
// Consumers: muldiv_seq, muldiv_step and the muldiv_seq_if bus.
package muldiv_seq_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FUNC_WIDTH = 6;
    localparam int CNT_WIDTH  = 5;

    localparam logic [FUNC_WIDTH-1:0] FUNC_MULT  = 6'h18;
    localparam logic [FUNC_WIDTH-1:0] FUNC_MULTU = 6'h19;
    localparam logic [FUNC_WIDTH-1:0] FUNC_DIV   = 6'h1A;
    localparam logic [FUNC_WIDTH-1:0] FUNC_DIVU  = 6'h1B;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fcn_valid(input logic [FUNC_WIDTH-1:0] f);
        return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

    function automatic logic fcn_is_div(input logic [FUNC_WIDTH-1:0] f);
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

    function automatic logic fcn_is_signed(input logic [FUNC_WIDTH-1:0] f);
        return (f == FUNC_MULT) || (f == FUNC_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/status bus between EX-stage decode and the multiply/divide sequencer.
// master = decode/pipeline side, slave = muldiv_seq.
interface muldiv_seq_if;
    import muldiv_seq_pkg::*;

    logic                  start_87;
    logic [FUNC_WIDTH-1:0] fcn_87;
    logic [DATA_WIDTH-1:0] arg_a_87;
    logic [DATA_WIDTH-1:0] arg_b_87;
    logic                  kill_87;
    logic                  wr_hi_87;
    logic                  wr_lo_87;
    logic [DATA_WIDTH-1:0] wdata_87;
    logic                  busy_87;
    logic                  done_87;
    logic [DATA_WIDTH-1:0] hi_87;
    logic [DATA_WIDTH-1:0] lo_87;

    modport master (
        output start_87, fcn_87, arg_a_87, arg_b_87, kill_87, wr_hi_87, wr_lo_87, wdata_87,
        input  busy_87, done_87, hi_87, lo_87
    );

    modport slave (
        input  start_87, fcn_87, arg_a_87, arg_b_87, kill_87, wr_hi_87, wr_lo_87, wdata_87,
        output busy_87, done_87, hi_87, lo_87
    );

endinterface

// File: rtl/muldiv_seq_step.sv
// One combinational iteration on {acc, q}: shift-add for multiply, restoring
// trial-subtract-shift for divide. After 32 iterations {acc, q} is {hi, lo}.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic [DATA_WIDTH-1:0] q_next
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH-1:0] diff;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, b};
        rem_sh   = {acc, q[DATA_WIDTH-1]};
        // Only used when rem_sh >= b, where the difference always fits in 32 bits.
        diff     = rem_sh[DATA_WIDTH-1:0] - b;
        acc_next = acc;
        q_next   = q;
        if (is_div) begin
            if (rem_sh >= {1'b0, b}) begin
                acc_next = diff;
                q_next   = {q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_sh[DATA_WIDTH-1:0];
                q_next   = {q[DATA_WIDTH-2:0], 1'b0};
            end
        end else if (q[0]) begin
            acc_next = sum[DATA_WIDTH:1];
            q_next   = {sum[0], q[DATA_WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[DATA_WIDTH-1:1]};
            q_next   = {acc[0], q[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// MIPS MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 32 iterations, commit, one-cycle done.
// Optional MULDIV_SIGNED_EN: signed MULT/DIV via operand abs() and result sign fixup.
//
//  state   | meaning
//  IDLE    | waiting for start; MTHI/MTLO accepted
//  RUN     | iterating, busy asserted; kill aborts without touching HI/LO
//  DONE    | HI/LO just committed; may accept a back-to-back start
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk_87,
    input  logic        rst_n_87,
    muldiv_seq_if.slave bus
);

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] acc, q, dvs;
    logic [DATA_WIDTH-1:0] hi, lo;
    logic [DATA_WIDTH-1:0] acc_nx, q_nx;
    logic [DATA_WIDTH-1:0] a_in, b_in;
    logic [DATA_WIDTH-1:0] commit_hi, commit_lo;
    logic                  is_div;
    logic                  accept;

    assign accept = bus.start_87 && !bus.kill_87 && fcn_valid(bus.fcn_87);

`ifdef MULDIV_SIGNED_EN
    logic sgn_op;
    logic neg_lo, neg_hi;

    assign sgn_op = fcn_is_signed(bus.fcn_87);
    assign a_in   = (sgn_op && bus.arg_a_87[DATA_WIDTH-1]) ? -bus.arg_a_87 : bus.arg_a_87;
    assign b_in   = (sgn_op && bus.arg_b_87[DATA_WIDTH-1]) ? -bus.arg_b_87 : bus.arg_b_87;
`else
    assign a_in   = bus.arg_a_87;
    assign b_in   = bus.arg_b_87;
`endif

    muldiv_step u_step (
        .is_div   (is_div),
        .acc      (acc),
        .q        (q),
        .b        (dvs),
        .acc_next (acc_nx),
        .q_next   (q_nx)
    );

    // Multiply leaves the product in {acc, q}; divide leaves {remainder, quotient}.
    always_comb begin
        commit_hi = acc_nx;
        commit_lo = q_nx;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_lo) commit_lo = -q_nx;
            if (neg_hi) commit_hi = -acc_nx;
        end else if (neg_lo) begin
            {commit_hi, commit_lo} = -{acc_nx, q_nx};
        end
`endif
    end

    always_ff @(posedge clk_87 or negedge rst_n_87) begin
        if (!rst_n_87) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            dvs    <= '0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.kill_87) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= acc_nx;
                        q   <= q_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            hi    <= commit_hi;
                            lo    <= commit_lo;
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    if (bus.wr_hi_87) hi <= bus.wdata_87;
                    if (bus.wr_lo_87) lo <= bus.wdata_87;
                    if (accept) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        acc    <= '0;
                        q      <= a_in;
                        dvs    <= b_in;
                        is_div <= fcn_is_div(bus.fcn_87);
`ifdef MULDIV_SIGNED_EN
                        neg_lo <= sgn_op && (bus.arg_a_87[DATA_WIDTH-1] ^ bus.arg_b_87[DATA_WIDTH-1]);
                        neg_hi <= sgn_op && bus.arg_a_87[DATA_WIDTH-1];
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy_87 = (state == ST_RUN);
    assign bus.done_87 = (state == ST_DONE);
    assign bus.hi_87   = hi;
    assign bus.lo_87   = lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, HI/LO results, MTHI/MTLO, kill, reset, signed build.
`timescale 1ns/1ps
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lat;
    int   nbusy;
    logic seen;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk_87   (clk),
        .rst_n_87 (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done_87 is seen (or budget spent).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lt, output int nb);
        bus.start_87 = 1'b1;
        bus.fcn_87   = f;
        bus.arg_a_87 = a;
        bus.arg_b_87 = b;
        @(negedge clk);
        bus.start_87 = 1'b0;
        lt = 1;
        nb = 0;
        while (bus.done_87 !== 1'b1 && lt < 100) begin
            if (bus.busy_87) nb++;
            @(negedge clk);
            lt++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start_87 = 1'b0;
        bus.fcn_87   = '0;
        bus.arg_a_87 = '0;
        bus.arg_b_87 = '0;
        bus.kill_87  = 1'b0;
        bus.wr_hi_87 = 1'b0;
        bus.wr_lo_87 = 1'b0;
        bus.wdata_87 = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy_87, 0);
        check("rst_done", bus.done_87, 0);
        check("rst_hi", bus.hi_87, 0);
        check("rst_lo", bus.lo_87, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nbusy);
        check("mulu_lat", lat, 33);
        check("mulu_busy", nbusy, 32);
        check("mulu_hi", bus.hi_87, 32'hFFFF_FFFE);
        check("mulu_lo", bus.lo_87, 32'h0000_0001);
        @(negedge clk);
        check("mulu_done_clr", bus.done_87, 0);

        run_op(FUNC_DIVU, 32'd100, 32'd7, lat, nbusy);
        check("divu_lat", lat, 33);
        check("divu_busy", nbusy, 32);
        check("divu_lo", bus.lo_87, 32'd14);
        check("divu_hi", bus.hi_87, 32'd2);
        @(negedge clk);
        check("divu_done_clr", bus.done_87, 0);

        run_op(FUNC_DIVU, 32'd5, 32'd0, lat, nbusy);
        check("div0_lo", bus.lo_87, 32'hFFFF_FFFF);
        check("div0_hi", bus.hi_87, 32'd5);
        bus.wr_hi_87 = 1'b1;
        bus.wdata_87 = 32'h0000_ABCD;
        @(negedge clk);
        bus.wr_hi_87 = 1'b0;
        check("mthi_done_hi", bus.hi_87, 32'h0000_ABCD);
        check("mthi_done_lo", bus.lo_87, 32'hFFFF_FFFF);

        bus.wr_lo_87 = 1'b1;
        bus.wdata_87 = 32'h0000_1234;
        @(negedge clk);
        bus.wr_lo_87 = 1'b0;
        check("mtlo_idle_lo", bus.lo_87, 32'h0000_1234);
        check("mtlo_idle_hi", bus.hi_87, 32'h0000_ABCD);

        // Kill at RUN cycle 10 with an MTHI attempted mid-run.
        bus.start_87 = 1'b1;
        bus.fcn_87   = FUNC_MULTU;
        bus.arg_a_87 = 32'd3;
        bus.arg_b_87 = 32'd5;
        @(negedge clk);
        bus.start_87 = 1'b0;
        for (int i = 1; i < 10; i++) begin
            bus.wr_hi_87 = (i == 5);
            bus.wdata_87 = 32'h0000_5555;
            @(negedge clk);
        end
        bus.wr_hi_87 = 1'b0;
        check("kill_busy_pre", bus.busy_87, 1);
        bus.kill_87 = 1'b1;
        @(negedge clk);
        bus.kill_87 = 1'b0;
        check("kill_busy", bus.busy_87, 0);
        check("kill_hi", bus.hi_87, 32'h0000_ABCD);
        check("kill_lo", bus.lo_87, 32'h0000_1234);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_87) seen = 1'b1;
        end
        check("kill_no_done", seen, 0);

        bus.start_87 = 1'b1;
        bus.fcn_87   = 6'h20;
        @(negedge clk);
        bus.start_87 = 1'b0;
        check("bad_fcn_busy", bus.busy_87, 0);

        bus.start_87 = 1'b1;
        bus.fcn_87   = FUNC_MULTU;
        bus.kill_87  = 1'b1;
        @(negedge clk);
        bus.start_87 = 1'b0;
        bus.kill_87  = 1'b0;
        check("kill_start_busy", bus.busy_87, 0);

        // A second start while running must not disturb the op in flight.
        bus.start_87 = 1'b1;
        bus.fcn_87   = FUNC_MULTU;
        bus.arg_a_87 = 32'd6;
        bus.arg_b_87 = 32'd7;
        @(negedge clk);
        for (int i = 1; i <= 32; i++) begin
            bus.start_87 = (i == 5);
            if (i == 5) begin
                bus.fcn_87   = FUNC_DIVU;
                bus.arg_a_87 = 32'd100;
                bus.arg_b_87 = 32'd7;
            end
            @(negedge clk);
        end
        bus.start_87 = 1'b0;
        check("run_start_done", bus.done_87, 1);
        check("run_start_lo", bus.lo_87, 32'd42);
        check("run_start_hi", bus.hi_87, 32'd0);
        @(negedge clk);

        run_op(FUNC_DIVU, 32'd1000, 32'd10, lat, nbusy);
        check("b2b1_lo", bus.lo_87, 32'd100);
        check("b2b1_hi", bus.hi_87, 32'd0);
        run_op(FUNC_DIVU, 32'd100, 32'd7, lat, nbusy);
        check("b2b2_lat", lat, 33);
        check("b2b2_lo", bus.lo_87, 32'd14);
        check("b2b2_hi", bus.hi_87, 32'd2);
        bus.kill_87 = 1'b1;
        @(negedge clk);
        bus.kill_87 = 1'b0;
        check("kill_done_hi", bus.hi_87, 32'd2);
        check("kill_done_lo", bus.lo_87, 32'd14);
        check("kill_done_busy", bus.busy_87, 0);

        run_op(FUNC_MULT, 32'hFFFF_FFFD, 32'd7, lat, nbusy);
`ifdef MULDIV_SIGNED_EN
        check("mult_neg", {bus.hi_87, bus.lo_87}, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        check("mult_neg", {bus.hi_87, bus.lo_87}, 64'h0000_0006_FFFF_FFEB);
`endif
        @(negedge clk);
        run_op(FUNC_DIV, 32'hFFFF_FF9C, 32'd7, lat, nbusy);
`ifdef MULDIV_SIGNED_EN
        check("div_neg", {bus.hi_87, bus.lo_87}, 64'hFFFF_FFFE_FFFF_FFF2);
`else
        check("div_neg", {bus.hi_87, bus.lo_87}, 64'h0000_0002_2492_4916);
`endif
        @(negedge clk);
        run_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, nbusy);
`ifdef MULDIV_SIGNED_EN
        check("div_ovf", {bus.hi_87, bus.lo_87}, 64'h0000_0000_8000_0000);
`else
        check("div_ovf", {bus.hi_87, bus.lo_87}, 64'h8000_0000_0000_0000);
`endif
        @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        bus.start_87 = 1'b1;
        bus.fcn_87   = FUNC_MULTU;
        bus.arg_a_87 = 32'hFFFF_FFFF;
        bus.arg_b_87 = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start_87 = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", bus.busy_87, 0);
        check("mrst_done", bus.done_87, 0);
        check("mrst_hi", bus.hi_87, 0);
        check("mrst_lo", bus.lo_87, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(FUNC_DIVU, 32'd100, 32'd7, lat, nbusy);
        check("mrst_after_lat", lat, 33);
        check("mrst_after_lo", bus.lo_87, 32'd14);
        check("mrst_after_hi", bus.hi_87, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
